// File: rtl/fpga_clk_rst_seq.sv
// Reset sequencer and multi-channel clock-enable generator for the FPGA top level.
// Holds the GPU core in reset until MMCM lock is stable, then emits programmable-rate strobes.
module fpga_clk_rst_seq #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned RST_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    locked,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic [NUM_CH-1:0]       en_i,
  output logic                    core_rst_n,
  output logic [NUM_CH-1:0]       ce_o,
  output logic [1:0]              state_o,
  output logic                    lock_lost
);

  typedef enum logic [1:0] {
    StReset    = 2'd0,
    StWaitLock = 2'd1,
    StHold     = 2'd2,
    StRun      = 2'd3
  } state_e;

  localparam int unsigned HoldW = $clog2(RST_HOLD + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD - 1);

  state_e           state_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic             lock_meta_q;
  logic             locked_s_q;
  logic             core_rst_n_q;
  logic             lock_lost_q;
  logic             ch_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StReset;
      hold_cnt_q   <= '0;
      lock_meta_q  <= 1'b0;
      locked_s_q   <= 1'b0;
      core_rst_n_q <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      lock_meta_q  <= locked;
      locked_s_q   <= lock_meta_q;
      // core_rst_n tracks the next state so it is high exactly while state is RUN
      core_rst_n_q <= 1'b0;
      unique case (state_q)
        StReset: state_q <= StWaitLock;
        StWaitLock: begin
          if (locked_s_q) begin
            state_q    <= StHold;
            hold_cnt_q <= '0;
          end
        end
        StHold: begin
          if (!locked_s_q) begin
            state_q     <= StWaitLock;
            lock_lost_q <= 1'b1;
          end else if (hold_cnt_q == HoldLast) begin
            state_q      <= StRun;
            core_rst_n_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + HoldW'(1);
          end
        end
        StRun: begin
          if (!locked_s_q) begin
            state_q     <= StWaitLock;
            lock_lost_q <= 1'b1;
          end else begin
            core_rst_n_q <= 1'b1;
          end
        end
        default: state_q <= StReset;
      endcase
    end
  end

  // Channels run only in cycles where the FSM stays in RUN, so lock loss stops strobes at once
  assign ch_run = (state_q == StRun) && locked_s_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_act_q;
    logic             ce_q;
    logic             wrap;

    assign wrap = (cnt_q == div_act_q);

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q     <= '0;
        div_act_q <= '0;
        ce_q      <= 1'b0;
      end else if (!ch_run || !en_i[c]) begin
        cnt_q     <= '0;
        div_act_q <= div_i[c*DIV_W +: DIV_W];
        ce_q      <= 1'b0;
      end else begin
        ce_q <= wrap;
        if (wrap) begin
          cnt_q     <= '0;
          div_act_q <= div_i[c*DIV_W +: DIV_W];
        end else begin
          cnt_q <= cnt_q + DIV_W'(1);
        end
      end
    end

    assign ce_o[c] = ce_q;
  end

  assign state_o    = state_q;
  assign core_rst_n = core_rst_n_q;
  assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_fpga_clk_rst_seq.sv
// Bench for fpga_clk_rst_seq: event-schedule reference model feeding a scoreboard queue,
// plus directed timing checks and a randomized soak.
module tb_fpga_clk_rst_seq;

  localparam int NUM_CH   = 2;
  localparam int DIV_W    = 8;
  localparam int RST_HOLD = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    locked;
  logic [NUM_CH*DIV_W-1:0] div_i;
  logic [NUM_CH-1:0]       en_i;
  logic                    core_rst_n;
  logic [NUM_CH-1:0]       ce_o;
  logic [1:0]              state_o;
  logic                    lock_lost;

  fpga_clk_rst_seq #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .RST_HOLD(RST_HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .locked    (locked),
    .div_i     (div_i),
    .en_i      (en_i),
    .core_rst_n(core_rst_n),
    .ce_o      (ce_o),
    .state_o   (state_o),
    .lock_lost (lock_lost)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic              rst_n;
    logic [NUM_CH-1:0] ce;
    logic [1:0]        st;
    logic              ll;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: lock pipeline as a two-entry history, HOLD as a countdown,
  // and each channel as a schedule of the absolute edge number of its next strobe.
  int m_s1 = 0, m_s2 = 0, m_st = 0, m_ll = 0, m_hold_left = 0, edge_n = 0;
  int m_next[NUM_CH];
  int ls;
  int act;
  exp_t e_new;

  always @(posedge clk) begin
    edge_n++;
    ls = m_s2;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_st = 0; m_ll = 0; act = 0;
    end else begin
      act  = (m_st == 3) && (ls != 0);
      m_s2 = m_s1;
      m_s1 = locked;
      case (m_st)
        0: m_st = 1;
        1: if (ls != 0) begin m_st = 2; m_hold_left = RST_HOLD; end
        2: begin
          if (ls == 0) begin m_st = 1; m_ll = 1; end
          else begin
            m_hold_left--;
            if (m_hold_left == 0) m_st = 3;
          end
        end
        default: if (ls == 0) begin m_st = 1; m_ll = 1; end
      endcase
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (act == 0 || !en_i[c]) begin
        e_new.ce[c] = 1'b0;
        m_next[c]   = edge_n + int'(div_i[c*DIV_W +: DIV_W]) + 1;
      end else begin
        e_new.ce[c] = (edge_n == m_next[c]);
        if (edge_n == m_next[c]) m_next[c] = edge_n + int'(div_i[c*DIV_W +: DIV_W]) + 1;
      end
    end
    e_new.rst_n = (m_st == 3);
    e_new.st    = 2'(m_st);
    e_new.ll    = (m_ll != 0);
    exp_q.push_back(e_new);
  end

  exp_t e_mon;
  always @(negedge clk) begin
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e_mon = exp_q.pop_front();
      check("sb_core_rst_n", 32'(core_rst_n), 32'(e_mon.rst_n));
      check("sb_ce_o", 32'(ce_o), 32'(e_mon.ce));
      check("sb_state_o", 32'(state_o), 32'(e_mon.st));
      check("sb_lock_lost", 32'(lock_lost), 32'(e_mon.ll));
    end
  end

  task automatic wait_state(input logic [1:0] st, input int budget);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (state_o != st && g < budget);
    check("wait_state_reached", 32'(state_o), 32'(st));
  endtask

  task automatic count_hold(output int h);
    h = 0;
    while (state_o == 2'd2 && h < 100) begin
      h++;
      @(negedge clk);
    end
  endtask

  int n0, n1, g, h;

  initial begin
    reset  = 1'b1;
    locked = 1'b0;
    div_i  = '0;
    en_i   = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("wait_lock_idle", 32'(state_o), 32'd1);
    check("idle_rst_n", 32'(core_rst_n), 32'd0);

    // Lock rises before edge 0
    div_i  = {8'd3, 8'd0};
    en_i   = 2'b11;
    locked = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("edge1_still_wait", 32'(state_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("edge2_hold", 32'(state_o), 32'd2);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("edge17_hold", 32'(state_o), 32'd2);
    check("edge17_rst_n", 32'(core_rst_n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("edge18_run", 32'(state_o), 32'd3);
    check("edge18_rst_n", 32'(core_rst_n), 32'd1);

    // Pulse counts over 40 cycles
    repeat (10) @(posedge clk);
    n0 = 0; n1 = 0;
    repeat (40) begin
      @(negedge clk);
      n0 += int'(ce_o[0]);
      n1 += int'(ce_o[1]);
    end
    check("ch0_pulses_40", 32'(n0), 32'd40);
    check("ch1_pulses_40", 32'(n1), 32'd10);

    // Divisor change mid-period
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!ce_o[1] && g < 50);
    check("ch1_pulse_seen", 32'(ce_o[1]), 32'd1);
    repeat (2) @(posedge clk);
    #2 div_i[15:8] = 8'd9;
    g = 2;
    forever begin
      @(negedge clk);
      if (ce_o[1] || g > 300) break;
      @(posedge clk);
      g++;
    end
    check("gap_after_change", 32'(g), 32'd4);
    for (int k = 0; k < 2; k++) begin
      g = 0;
      do begin
        @(posedge clk);
        g++;
        @(negedge clk);
      end while (!ce_o[1] && g < 300);
      check("gap_new_div", 32'(g), 32'd10);
    end

    // Lock loss in RUN
    @(posedge clk);
    #2 locked = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("lockdrop_k1_rst_n", 32'(core_rst_n), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("lockdrop_rst_n", 32'(core_rst_n), 32'd0);
    check("lockdrop_ce", 32'(ce_o), 32'd0);
    check("lockdrop_sticky", 32'(lock_lost), 32'd1);
    check("lockdrop_state", 32'(state_o), 32'd1);
    @(posedge clk);
    #2 locked = 1'b1;
    wait_state(2'd2, 20);
    count_hold(h);
    check("relock_hold_len", 32'(h), 32'd16);
    check("relock_run", 32'(state_o), 32'd3);

    // Reset mid-HOLD at hold_cnt=8
    @(posedge clk);
    #2 locked = 1'b0;
    wait_state(2'd1, 20);
    @(posedge clk);
    #2 locked = 1'b1;
    wait_state(2'd2, 20);
    repeat (8) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midhold_reset_state", 32'(state_o), 32'd0);
    check("reset_clears_sticky", 32'(lock_lost), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    wait_state(2'd2, 20);
    count_hold(h);
    check("post_reset_hold_len", 32'(h), 32'd16);

    // Randomized soak, checked by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 199) == 0) locked = ~locked;
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 9) == 0)
          div_i[c*DIV_W +: DIV_W] = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 6));
        if ($urandom_range(0, 49) == 0) en_i[c] = ~en_i[c];
      end
    end
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
